// File: rtl/path_monitor_pkg.sv
// Shared types and defaults for the delay-chain path monitor.
// Sync depth sets the fixed offset added to every measured sample.
package path_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int DEF_SETTLE  = 16;
  localparam int DEF_TIMEOUT = 1000;
  // A zero-delay loopback reads back as this many cycles
  localparam int SYNC_DEPTH  = 2;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// Synchronous reset clears both stages to 0.
module bit_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/path_delay_monitor.sv
// Launches transitions into a delay chain and measures, in cycles,
// how long each takes to return; reports min/max/sum per run.
module path_delay_monitor
  import path_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TRIAL_W = 8,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SETTLE  = DEF_SETTLE,
  parameter bit INVERT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TRIAL_W-1:0]       trials,
  output logic                     pathInput,
  input  logic                     pathResult,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [TRIAL_W-1:0]       trialsDone,
  output logic [CNT_W-1:0]         minDelay,
  output logic [CNT_W-1:0]         maxDelay,
  output logic [CNT_W+TRIAL_W-1:0] sumDelay
);

  state_t state, state_nx;

  logic               sync_out;
  logic               expect_lvl;
  logic [TRIAL_W-1:0] trials_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   settle_cnt;
  logic               accept;
  logic               match;
  logic               last;
  logic               expired;
  logic               settled;

  bit_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pathResult),
    .q   (sync_out)
  );

  // done is high in the IDLE cycle after DONE; a start there is dropped
  assign accept  = start && !done;
  assign match   = sync_out == expect_lvl;
  assign last    = ({1'b0, trialsDone} + (TRIAL_W+1)'(1))
                   == {1'b0, trials_q};
  assign expired = cnt == CNT_W'(TIMEOUT - 1);
  assign settled = settle_cnt == CNT_W'(SETTLE - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = (trials == '0) ? S_DONE : S_SETTLE;
      end
      S_SETTLE: if (settled) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (match)        state_nx = last ? S_DONE : S_SETTLE;
        else if (expired) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pathInput  <= 1'b0;
      expect_lvl <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      trials_q   <= '0;
      trialsDone <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      minDelay   <= '1;
      maxDelay   <= '0;
      sumDelay   <= '0;
    end else begin
      done       <= 1'b0;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            busy       <= 1'b1;
            trials_q   <= trials;
            trialsDone <= '0;
            timeout    <= 1'b0;
            minDelay   <= '1;
            maxDelay   <= '0;
            sumDelay   <= '0;
          end
        end
        S_LAUNCH: begin
          pathInput  <= ~pathInput;
          expect_lvl <= ~pathInput ^ INVERT;
          cnt        <= '0;
        end
        S_WAIT: begin
          if (match) begin
            if (cnt < minDelay) minDelay <= cnt;
            if (cnt > maxDelay) maxDelay <= cnt;
            sumDelay   <= sumDelay + {{TRIAL_W{1'b0}}, cnt};
            trialsDone <= trialsDone + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (expired) timeout <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/path_delay_monitor.md
# path_delay_monitor

Launch/capture controller for the delay-chain sensor paths: drives the chain input, watches the chain output, and measures in clock cycles how long each launched transition takes to propagate. It runs a programmable number of trials per request and reports min, max and sum of the per-trial samples plus a timeout flag. It sits between the host register interface and one instantiated `singlepath_*` chain, driving `pathInput` and sampling `pathResult`.

## Interface
- `CNT_W`, 16: width of the per-trial cycle counter and of `minDelay`/`maxDelay`.
- `TRIAL_W`, 8: width of the trial-count request and of `trialsDone`.
- `TIMEOUT`, 1000: WAIT cycles allowed per trial before abort; must be < 2^CNT_W.
- `SETTLE`, 16: idle cycles before each launch; must be ≥ 1.
- `INVERT`, 0: 1 when the attached chain is net-inverting (odd stage count).
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `trials`  in  TRIAL_W  trial count, sampled on accepted `start`.
- `pathInput`  out  1  registered drive to the chain input.
- `pathResult`  in  1  asynchronous chain output.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of run.
- `timeout`  out  1  sticky per run: last trial aborted.
- `trialsDone`  out  TRIAL_W  completed trials.
- `minDelay`, `maxDelay`  out  CNT_W  extremes of samples.
- `sumDelay`  out  CNT_W+TRIAL_W  sum of samples.

## Operation
- `pathResult` passes through a 2-flop synchronizer; all comparisons use the synchronized value `syncOut`.
- FSM states: IDLE, SETTLE, LAUNCH, WAIT, DONE.
- IDLE: on `start`, latch `trials` and clear stats (`min` = all ones, `max`/`sum`/`trialsDone`/`timeout` = 0). If `trials` = 0, go to DONE. Otherwise go to SETTLE.
- SETTLE: count `SETTLE` cycles, then go to LAUNCH.
- LAUNCH: `pathInput` <= ~`pathInput`, set `expect` = new `pathInput` ^ `INVERT`, clear `cnt`, go to WAIT.
- WAIT: each cycle, if `syncOut` == `expect`:
  - sample = `cnt`; update min, max and sum.
  - Increment `trialsDone`.
  - Go to DONE if `trialsDone`+1 == latched trials, else go to SETTLE.
- WAIT, no match: `cnt` increments. When `cnt` == `TIMEOUT`-1 without a match, set `timeout`, record nothing, and go to DONE (run aborted).
- DONE: pulse `done` for one cycle, drop `busy`, go to IDLE.
- Stats hold until the next accepted `start`.
- Arithmetic: `sum` is wide enough for 2^TRIAL_W−1 samples and never wraps. `cnt` cannot wrap because `TIMEOUT` < 2^CNT_W.
- Reset mid-run: all state returns to reset values next cycle; `pathInput` returns to 0.

## Timing
- Reset values: `pathInput`=0, `busy`=0, `done`=0, `timeout`=0, `trialsDone`=0, `minDelay`=all ones, `maxDelay`=0, `sumDelay`=0, FSM=IDLE.
- `busy` rises the cycle after an accepted `start`.
- Zero-delay loopback (`pathResult`=`pathInput`^`INVERT`) yields sample = 2, the synchronizer latency.
  - A chain delay of d full cycles yields 2+d.
- Per-trial period: 1 (LAUNCH) + sample+1 (WAIT) + `SETTLE`.
- Run with `trials`=0: `done` two cycles after `start` (IDLE→DONE→IDLE).
- `start` coincident with `done` is ignored.
- `start` in the cycle after `done` is accepted.

## Structure
- Package `path_monitor_pkg`:
  - FSM state enum.
  - Default constants for `SETTLE`/`TIMEOUT`.
  - Synchronizer depth constant (2), used to document the sample offset.
- Sub-module `bit_sync2`: 2-flop synchronizer with synchronous reset to 0. It is reused by other sensor readers.
- All remaining logic lives in one FSM plus datapath module.

## Test plan
- Loopback, `INVERT`=0, `trials`=4 → min=max=2, sum=8, `trialsDone`=4, `timeout`=0, one `done` pulse.
- Behavioural chain delay of 5 cycles, `INVERT`=1, `trials`=3 → min=max=7, sum=21.
- Delay alternating 3 and 6 cycles, `trials`=4 → min=5, max=8, sum=26.
- `pathResult` stuck at 0 with `INVERT`=0 → `timeout`=1 after 1000 WAIT cycles, `trialsDone`=0, `done` pulses.
- `trials`=0 → `done` two cycles after `start`, no `pathInput` toggle, min=all ones.
- `rst` asserted during WAIT of trial 2 → next cycle all outputs at reset values. A `start` issued afterwards must produce a correct run, and a second `start` while busy must be ignored.
